// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for a 4-bit display counter: start/pause/resume/clear/load
// with a run-time rate divider; ports C,Reset in; Start/Stop/Clear/Load/LoadVal/RateSel/Q in; Cl/Pl/D/En/Busy/Done/State out.
module counter_seq_ctrl #(
    parameter logic [27:0] RATE0 = 28'd0,
    parameter logic [27:0] RATE1 = 28'd3,
    parameter logic [27:0] RATE2 = 28'd7,
    parameter logic [27:0] RATE3 = 28'd11,
    parameter logic [3:0]  TERM  = 4'd9
) (
    input  logic       C,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
    input  logic       Load,
    input  logic [3:0] LoadVal,
    input  logic [1:0] RateSel,
    input  logic [3:0] Q,
    output logic       Cl,
    output logic       Pl,
    output logic [3:0] D,
    output logic       En,
    output logic       Busy,
    output logic       Done,
    output logic [1:0] State
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [27:0] div_q, div_d;
    logic [27:0] rate_q, rate_d;
    logic [1:0]  rsel_q;
    logic        cl_q, cl_d;
    logic        pl_q, pl_d;
    logic [3:0]  d_q, d_d;

    logic        rate_chg;
    logic        at_rate;
    logic        at_term;

    function automatic logic [27:0] rate_of(input logic [1:0] sel);
        logic [27:0] r;
        case (sel)
            2'b00:   r = RATE0;
            2'b01:   r = RATE1;
            2'b10:   r = RATE2;
            default: r = RATE3;
        endcase
        return r;
    endfunction

    always_ff @(posedge C) begin
        if (Reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            rate_q  <= rate_of(RateSel);
            rsel_q  <= RateSel;
            cl_q    <= 1'b0;
            pl_q    <= 1'b0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            rate_q  <= rate_d;
            rsel_q  <= RateSel;
            cl_q    <= cl_d;
            pl_q    <= pl_d;
            d_q     <= d_d;
        end
    end

    // While the clear pulse is out the counter's Q is stale, so the
    // terminal test and the enable both wait for Cl to return high.
    assign rate_chg = (RateSel != rsel_q);
    assign at_rate  = (div_q == rate_q);
    assign at_term  = cl_q && (Q == TERM);

    // Stop/Clear suppress the step so a divider frozen at its terminal
    // value does not step the counter twice across a pause.
    assign En = (state_q == S_RUN) && cl_q && at_rate && (Q != TERM)
             && !rate_chg && !Stop && !Clear && !Reset;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        rate_d  = rate_q;
        cl_d    = 1'b1;
        pl_d    = 1'b0;
        d_d     = d_q;

        if (Clear) begin
            state_d = S_IDLE;
            cl_d    = 1'b0;
            div_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Stop) begin
                        state_d = S_IDLE;
                    end else if (Start) begin
                        state_d = S_RUN;
                        div_d   = '0;
                    end else if (Load) begin
                        pl_d = 1'b1;
                        d_d  = LoadVal;
                    end
                end
                S_RUN: begin
                    if (Stop) begin
                        state_d = S_PAUSE;
                    end else if (at_term) begin
                        state_d = S_DONE;
                        div_d   = '0;
                    end else begin
                        div_d = at_rate ? 28'd0 : div_q + 28'd1;
                    end
                end
                S_PAUSE: begin
                    if (Stop) begin
                        state_d = S_PAUSE;
                    end else if (Start) begin
                        state_d = S_RUN;
                    end else if (Load) begin
                        pl_d = 1'b1;
                        d_d  = LoadVal;
                    end
                end
                default: begin
                    if (Stop) begin
                        state_d = S_DONE;
                    end else if (Start) begin
                        state_d = S_RUN;
                        cl_d    = 1'b0;
                        div_d   = '0;
                    end else if (Load) begin
                        pl_d = 1'b1;
                        d_d  = LoadVal;
                    end
                end
            endcase
        end

        // A new rate restarts the divider from zero in every state.
        if (rate_chg) begin
            rate_d = rate_of(RateSel);
            div_d  = '0;
        end
    end

    assign Cl    = cl_q;
    assign Pl    = pl_q;
    assign D     = d_q;
    assign Busy  = (state_q == S_RUN);
    assign Done  = (state_q == S_DONE);
    assign State = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 4-bit counter
// (sync active-low clear > load > enable) closing the Q feedback loop.
module tb_counter_seq_ctrl;

    logic       C = 1'b0;
    logic       Reset, Start, Stop, Clear, Load;
    logic [3:0] LoadVal;
    logic [1:0] RateSel;
    logic [3:0] q = 4'd0;
    logic       Cl, Pl, En, Busy, Done;
    logic [3:0] D;
    logic [1:0] State;

    int checks = 0;
    int errors = 0;

    counter_seq_ctrl dut (
        .C(C), .Reset(Reset), .Start(Start), .Stop(Stop),
        .Clear(Clear), .Load(Load), .LoadVal(LoadVal),
        .RateSel(RateSel), .Q(q), .Cl(Cl), .Pl(Pl), .D(D),
        .En(En), .Busy(Busy), .Done(Done), .State(State)
    );

    always #5 C = ~C;

    always @(posedge C) begin
        if (!Cl)     q <= 4'd0;
        else if (Pl) q <= D;
        else if (En) q <= q + 4'd1;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge C);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        Reset = 1; Start = 0; Stop = 0; Clear = 0; Load = 0;
        LoadVal = 0; RateSel = 2'b01;

        // reset
        tick(); Reset = 0; #1;
        chk("rst_cl", Cl, 0);
        chk("rst_state", State, 0);
        chk("rst_en", En, 0);
        chk("rst_done", Done, 0);
        chk("rst_busy", Busy, 0);
        tick(); #1;
        chk("rst_cl_rel", Cl, 1);
        chk("rst_q", q, 0);

        // rate 01 full run
        tick(); Start = 1;
        for (int k = 1; k <= 36; k++) begin
            tick(); Start = 0; #1;
            chk("a_en", En, (k % 4) == 0);
        end
        tick(); #1;
        chk("a_en_term", En, 0);
        chk("a_q9", q, 9);
        chk("a_busy", Busy, 1);
        tick(); #1;
        chk("a_state", State, 3);
        chk("a_done", Done, 1);
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            chk("a_en_done", En, 0);
        end
        chk("a_q_hold", q, 9);

        // rate 00 restart from DONE
        tick(); RateSel = 2'b00;
        tick(); Start = 1; #1;
        chk("b_en_chg", En, 0);
        tick(); Start = 0; #1;
        chk("b_cl", Cl, 0);
        chk("b_state", State, 1);
        chk("b_en_r1", En, 0);
        for (int k = 2; k <= 10; k++) begin
            tick(); #1;
            chk("b_en", En, 1);
            chk("b_q", q, k - 2);
        end
        tick(); #1;
        chk("b_en_term", En, 0);
        chk("b_q9", q, 9);
        tick(); #1;
        chk("b_state_done", State, 3);

        // pause / resume
        tick(); RateSel = 2'b01;
        tick(); Start = 1;
        tick(); Start = 0; #1;
        chk("c_cl", Cl, 0);
        tick();
        tick(); Stop = 1; #1;
        chk("c_en_stop", En, 0);
        for (int p = 1; p <= 4; p++) begin
            tick(); Start = (p == 2); #1;
            chk("c_state_p", State, 2);
            chk("c_en_p", En, 0);
            chk("c_q_p", q, 0);
        end
        tick(); Stop = 0; Start = 1; #1;
        chk("c_state_res", State, 2);
        tick(); Start = 0; #1;
        chk("c_state_run", State, 1);
        chk("c_en_u1", En, 0);
        tick(); #1;
        chk("c_en_u2", En, 1);
        tick(); Clear = 1; #1;
        chk("c_q1", q, 1);
        tick(); Clear = 0; #1;
        chk("c_clr_state", State, 0);
        chk("c_clr_cl", Cl, 0);
        tick(); #1;
        chk("c_clr_cl1", Cl, 1);
        chk("c_clr_q", q, 0);

        // load 7 then run to 9
        tick(); LoadVal = 7; Load = 1;
        tick(); Load = 0; Start = 1; #1;
        chk("d_pl", Pl, 1);
        chk("d_d", D, 7);
        for (int k = 1; k <= 9; k++) begin
            tick(); Start = 0; #1;
            chk("d_en", En, (k == 4) || (k == 8));
            if (k == 1) begin
                chk("d_pl0", Pl, 0);
                chk("d_q7", q, 7);
            end
        end
        chk("d_q9", q, 9);
        tick(); #1;
        chk("d_state", State, 3);

        // start with Q already at terminal
        tick(); Clear = 1;
        tick(); Clear = 0; LoadVal = 9; Load = 1;
        tick(); Load = 0; Start = 1; #1;
        chk("e_pl", Pl, 1);
        tick(); Start = 0; #1;
        chk("e_q9", q, 9);
        chk("e_busy", Busy, 1);
        chk("e_en", En, 0);
        tick(); #1;
        chk("e_state", State, 3);

        // mid-run rate change, then clear
        tick(); Clear = 1;
        tick(); Clear = 0;
        tick(); Start = 1;
        tick(); Start = 0;
        tick(); RateSel = 2'b11; #1;
        chk("f_en_chg", En, 0);
        for (int c = 1; c <= 12; c++) begin
            tick(); #1;
            chk("f_en", En, c == 12);
        end
        tick(); Clear = 1;
        tick(); Clear = 0; #1;
        chk("f_state", State, 0);
        chk("f_cl", Cl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
